// File: rtl/otter_io_pkg.sv
// otter_io_pkg
//   Shared definitions for the OTTER IOBUS devices. Holds the IOBUS register
//   addresses (also used by the write-side output-port logic), a register
//   selector enum with its address decoder, and a small helper that builds
//   low-order bit masks.
package otter_io_pkg;

  localparam logic [31:0] SW_ADDR   = 32'h1100_8000;
  localparam logic [31:0] BTN_ADDR  = 32'h1100_8004;
  localparam logic [31:0] PEND_ADDR = 32'h1100_8008;
  localparam logic [31:0] MASK_ADDR = 32'h1100_C010;

  // Pending/mask bit reserved for the optional switch-change interrupt.
  localparam int SW_IRQ_BIT = 31;

  typedef enum logic [2:0] {
    REG_SW   = 3'd0,
    REG_BTN  = 3'd1,
    REG_PEND = 3'd2,
    REG_MASK = 3'd3,
    REG_NONE = 3'd4
  } io_reg_e;

  // Map an IOBUS address onto the register it selects.
  function automatic io_reg_e decode_addr(input logic [31:0] addr);
    io_reg_e sel;
    case (addr)
      SW_ADDR:   sel = REG_SW;
      BTN_ADDR:  sel = REG_BTN;
      PEND_ADDR: sel = REG_PEND;
      MASK_ADDR: sel = REG_MASK;
      default:   sel = REG_NONE;
    endcase
    return sel;
  endfunction

  // 32-bit mask with the low n bits set.
  function automatic logic [31:0] low_mask(input int n);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/otter_io_input_port_if.sv
// otter_io_input_port_if
//   IOBUS signal bundle between the MCU and an IOBUS device.
//   iobus_addr : address driven by the MCU
//   iobus_out  : write data driven by the MCU
//   iobus_wr   : write strobe driven by the MCU
//   iobus_in   : read data returned by the device
//   Modports: master (MCU side), slave (device side).
interface otter_io_input_port_if;

  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;

  modport master (
    output iobus_addr,
    output iobus_out,
    output iobus_wr,
    input  iobus_in
  );

  modport slave (
    input  iobus_addr,
    input  iobus_out,
    input  iobus_wr,
    output iobus_in
  );

endinterface

// File: rtl/otter_io_input_port_debounce.sv
// io_debounce
//   W-bit two-flop synchronizer followed by a per-bit stability counter.
//   A debounced bit changes only after the synchronized input has disagreed
//   with it for DB_CYCLES consecutive clocks; any agreement restarts the count.
//   Ports:
//     clk  : clock, posedge
//     RST  : synchronous active-low reset
//     raw  : asynchronous raw inputs
//     db   : registered debounced outputs
module io_debounce #(
  parameter int W         = 1,
  parameter int DB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         RST,
  input  logic [W-1:0] raw,
  output logic [W-1:0] db
);

  // Counter only has to hold 0..DB_CYCLES-1; the flip happens on the step
  // that would reach DB_CYCLES.
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [W-1:0]     sync1_r;
  logic [W-1:0]     sync2_r;
  logic [W-1:0]     db_r;
  logic [CNT_W-1:0] cnt_r [W];

  // Synchronizer chain, stability counters and debounced state.
  always_ff @(posedge clk) begin
    if (!RST) begin
      sync1_r <= '0;
      sync2_r <= '0;
      db_r    <= '0;
      for (int i = 0; i < W; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      for (int i = 0; i < W; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          db_r[i]  <= ~db_r[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  assign db = db_r;

endmodule

// File: rtl/otter_io_input_port.sv
// otter_io_input_port
//   IOBUS read-side responder for the OTTER buttons and switches. Debounces
//   the raw inputs, serves them to MCU loads, latches button presses into a
//   write-1-to-clear pending register and raises a masked level interrupt.
//   Ports:
//     clk      : clock, posedge
//     RST      : synchronous active-low reset
//     buttons  : raw asynchronous buttons (N_BTN)
//     switches : raw asynchronous switches (N_SW)
//     bus      : IOBUS slave (addr, write data, write strobe, read data)
//     intr     : registered interrupt request, |(pending & mask)
//   Build option: define OTTER_IO_SW_IRQ_EN to latch any debounced switch
//   change into pending[31] (gated by mask[31]); otherwise bit 31 is absent.
module otter_io_input_port
  import otter_io_pkg::*;
#(
  parameter int N_BTN     = 5,
  parameter int N_SW      = 16,
  parameter int DB_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [N_BTN-1:0]       buttons,
  input  logic [N_SW-1:0]        switches,
  otter_io_input_port_if.slave   bus,
  output logic                   intr
);

  // Bits of pending/mask that physically exist; all others read as 0.
`ifdef OTTER_IO_SW_IRQ_EN
  localparam logic [31:0] IMPL_MASK = low_mask(N_BTN) | (32'h1 << SW_IRQ_BIT);
`else
  localparam logic [31:0] IMPL_MASK = low_mask(N_BTN);
`endif

  logic [N_BTN-1:0] db_btn_s;
  logic [N_SW-1:0]  db_sw_s;
  logic [N_BTN-1:0] btn_prev_r;
  logic [31:0]      pend_r;
  logic [31:0]      mask_r;
  logic             intr_r;
  logic [31:0]      set_s;
  logic [31:0]      clr_s;
  logic [31:0]      pend_nxt_s;
  logic [31:0]      mask_nxt_s;
  io_reg_e          sel_s;

  io_debounce #(.W(N_BTN), .DB_CYCLES(DB_CYCLES)) u_db_btn (
    .clk (clk),
    .RST (RST),
    .raw (buttons),
    .db  (db_btn_s)
  );

  io_debounce #(.W(N_SW), .DB_CYCLES(DB_CYCLES)) u_db_sw (
    .clk (clk),
    .RST (RST),
    .raw (switches),
    .db  (db_sw_s)
  );

  assign sel_s = decode_addr(bus.iobus_addr);

`ifdef OTTER_IO_SW_IRQ_EN
  logic [N_SW-1:0] sw_prev_r;

  // Previous debounced switches, for change detection.
  always_ff @(posedge clk) begin
    if (!RST) begin
      sw_prev_r <= '0;
    end else begin
      sw_prev_r <= db_sw_s;
    end
  end
`endif

  // Next-state pending and mask: press/change sets, W1C clears, set wins.
  always_comb begin
    set_s = 32'h0;
    set_s[N_BTN-1:0] = db_btn_s & ~btn_prev_r;
`ifdef OTTER_IO_SW_IRQ_EN
    set_s[SW_IRQ_BIT] = |(db_sw_s ^ sw_prev_r);
`endif
    if (bus.iobus_wr && (sel_s == REG_PEND)) begin
      clr_s = bus.iobus_out;
    end else begin
      clr_s = 32'h0;
    end
    pend_nxt_s = ((pend_r & ~clr_s) | set_s) & IMPL_MASK;
    if (bus.iobus_wr && (sel_s == REG_MASK)) begin
      mask_nxt_s = bus.iobus_out & IMPL_MASK;
    end else begin
      mask_nxt_s = mask_r;
    end
  end

  // Edge history, pending, mask and interrupt registers.
  always_ff @(posedge clk) begin
    if (!RST) begin
      btn_prev_r <= '0;
      pend_r     <= 32'h0;
      mask_r     <= 32'h0;
      intr_r     <= 1'b0;
    end else begin
      btn_prev_r <= db_btn_s;
      pend_r     <= pend_nxt_s;
      mask_r     <= mask_nxt_s;
      intr_r     <= |(pend_nxt_s & mask_nxt_s);
    end
  end

  assign intr = intr_r;

  // Read data mux; debounced inputs are zero-extended.
  always_comb begin
    bus.iobus_in = 32'h0;
    case (sel_s)
      REG_SW:   bus.iobus_in[N_SW-1:0]  = db_sw_s;
      REG_BTN:  bus.iobus_in[N_BTN-1:0] = db_btn_s;
      REG_PEND: bus.iobus_in = pend_r;
      REG_MASK: bus.iobus_in = mask_r;
      default:  bus.iobus_in = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_otter_io_input_port.sv
// tb_otter_io_input_port
//   Directed self-checking bench for otter_io_input_port with DB_CYCLES=4.
//   Inputs are driven and outputs sampled 1 time unit after each posedge.
module tb_otter_io_input_port;
  import otter_io_pkg::*;

  localparam logic [31:0] UNUSED_ADDR = 32'h1100_8010;
`ifdef OTTER_IO_SW_IRQ_EN
  localparam logic [31:0] SW_PEND   = 32'h8000_0000;
  localparam logic [31:0] MASK_FULL = 32'h8000_001F;
`else
  localparam logic [31:0] SW_PEND   = 32'h0;
  localparam logic [31:0] MASK_FULL = 32'h0000_001F;
`endif

  logic        clk;
  logic        RST;
  logic [4:0]  buttons;
  logic [15:0] switches;
  logic        intr;
  int          n_chk;
  int          n_pass;

  otter_io_input_port_if bus ();

  otter_io_input_port #(.N_BTN(5), .N_SW(16), .DB_CYCLES(4)) dut (
    .clk      (clk),
    .RST      (RST),
    .buttons  (buttons),
    .switches (switches),
    .bus      (bus),
    .intr     (intr)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 32'h%08h expected 32'h%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.iobus_addr = addr;
    #1;
    check_eq(tag, bus.iobus_in, exp);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.iobus_addr = addr;
    bus.iobus_out  = data;
    bus.iobus_wr   = 1'b1;
    tick(1);
    bus.iobus_wr   = 1'b0;
    bus.iobus_out  = 32'h0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    RST            = 1'b0;
    buttons        = 5'h0;
    switches       = 16'h0;
    bus.iobus_addr = 32'h0;
    bus.iobus_out  = 32'h0;
    bus.iobus_wr   = 1'b0;

    // Reset state.
    tick(3);
    check_eq("rst_intr", {31'h0, intr}, 32'h0);
    read_chk("rst_sw", SW_ADDR, 32'h0);
    read_chk("rst_btn", BTN_ADDR, 32'h0);
    read_chk("rst_pend", PEND_ADDR, 32'h0);
    read_chk("rst_mask", MASK_ADDR, 32'h0);
    read_chk("rst_other", UNUSED_ADDR, 32'h0);
    RST = 1'b1;
    tick(1);

    // Switch debounce latency: 5 clocks still old, new value at clock 6.
    switches = 16'hA5A5;
    bus.iobus_addr = SW_ADDR;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check_eq($sformatf("sw_wait%0d", i), bus.iobus_in, 32'h0);
    end
    tick(1);
    check_eq("sw_settled", bus.iobus_in, 32'h0000_A5A5);

    // Short glitch never reaches the debounced value.
    switches = 16'hFFFF;
    tick(2);
    switches = 16'hA5A5;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check_eq($sformatf("sw_glitch%0d", i), bus.iobus_in, 32'h0000_A5A5);
    end

    // Flush any switch-change event, unimplemented mask bits read 0.
    bus_write(PEND_ADDR, 32'hFFFF_FFFF);
    read_chk("pend_flushed", PEND_ADDR, 32'h0);
    bus_write(MASK_ADDR, 32'hFFFF_FFFF);
    read_chk("mask_impl", MASK_ADDR, MASK_FULL);

    // Press and interrupt.
    bus_write(MASK_ADDR, 32'h1);
    buttons = 5'h01;
    tick(10);
    read_chk("btn0_held", BTN_ADDR, 32'h1);
    buttons = 5'h00;
    read_chk("press0_pend", PEND_ADDR, 32'h1);
    check_eq("press0_intr", {31'h0, intr}, 32'h1);
    tick(8);
    read_chk("release0_pend", PEND_ADDR, 32'h1);
    bus_write(PEND_ADDR, 32'h1);
    read_chk("w1c0_pend", PEND_ADDR, 32'h0);
    check_eq("w1c0_intr", {31'h0, intr}, 32'h0);

    // Masked press does not interrupt until unmasked.
    bus_write(MASK_ADDR, 32'h0);
    buttons = 5'h04;
    tick(10);
    buttons = 5'h00;
    tick(8);
    read_chk("press2_pend", PEND_ADDR, 32'h4);
    check_eq("press2_intr_masked", {31'h0, intr}, 32'h0);
    bus_write(MASK_ADDR, 32'h4);
    read_chk("mask4", MASK_ADDR, 32'h4);
    check_eq("unmask_intr", {31'h0, intr}, 32'h1);

    // Set and W1C of bit 1 in the same clock: set wins.
    buttons = 5'h02;
    tick(6);
    read_chk("collide_before", PEND_ADDR, 32'h4);
    bus_write(PEND_ADDR, 32'h2);
    read_chk("collide_pend", PEND_ADDR, 32'h6);
    check_eq("collide_intr", {31'h0, intr}, 32'h1);
    buttons = 5'h00;
    tick(8);
    bus_write(PEND_ADDR, 32'hFFFF_FFFF);
    read_chk("clear_all", PEND_ADDR, 32'h0);
    check_eq("clear_all_intr", {31'h0, intr}, 32'h0);

    // Switch-change interrupt (present only with OTTER_IO_SW_IRQ_EN).
    bus_write(MASK_ADDR, 32'h8000_0000);
    switches = 16'hA525;
    tick(8);
    read_chk("sw7_value", SW_ADDR, 32'h0000_A525);
    read_chk("sw7_pend", PEND_ADDR, SW_PEND);
    check_eq("sw7_intr", {31'h0, intr}, SW_PEND[31] ? 32'h1 : 32'h0);
    bus_write(MASK_ADDR, 32'h0);
    switches = 16'h0;
    tick(8);
    bus_write(PEND_ADDR, 32'hFFFF_FFFF);

    // Reset mid-debounce with a button held through reset.
    buttons = 5'h01;
    tick(3);
    RST = 1'b0;
    tick(1);
    RST = 1'b1;
    read_chk("midrst_btn", BTN_ADDR, 32'h0);
    read_chk("midrst_pend", PEND_ADDR, 32'h0);
    tick(5);
    read_chk("postrst_btn5", BTN_ADDR, 32'h0);
    tick(1);
    read_chk("postrst_btn6", BTN_ADDR, 32'h1);
    read_chk("postrst_pend6", PEND_ADDR, 32'h0);
    tick(1);
    read_chk("postrst_pend7", PEND_ADDR, 32'h1);
    check_eq("postrst_intr", {31'h0, intr}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
